aes_subbytes_seq: RTL and testbench
===================================

# aes_subbytes_seq

Sequential SubBytes/InvSubBytes stage for a 128-bit AES state. It accepts a full block over a valid/ready handshake and streams its 16 bytes, one per cycle, through a single `sbox_full_rom` instance. It reassembles the substituted bytes and presents the result on an output valid/ready handshake. It sits between the AddRoundKey/round-control logic and ShiftRows, and trades latency for a single S-box instance.

## Interface
- No parameters; all widths fixed (block 128 bits, byte 8 bits, 16 bytes).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `encrypt`  in  1  1 = forward S-box (SubBytes), 0 = inverse (InvSubBytes); sampled only on input handshake.
- `in_valid`  in  1  `state_in` and `encrypt` are valid.
- `in_ready`  out  1  block can accept a new state.
- `state_in`  in  128  input state; byte i = `state_in[127-8i -: 8]` (byte 0 is MSB byte, FIPS-197 input order).
- `out_valid`  out  1  `state_out` holds a complete substituted block.
- `out_ready`  in  1  downstream consumes `state_out`.
- `state_out`  out  128  substituted state, same byte ordering as `state_in`.
- `busy`  out  1  high while bytes are being substituted.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `state_in` into the working register, latch `encrypt` into `mode_q`, clear the byte counter `cnt` (4 bits) to 0, and go to BUSY.
- BUSY:
  - The S-box input is working byte[`cnt`] and the mode is `mode_q`.
  - At each clock edge, the S-box output overwrites working byte[`cnt`] and `cnt` increments.
  - On the edge where `cnt`==15 is written, go to DONE. `cnt` wraps to 0 and is not used until it is reloaded.
  - `in_valid` is ignored; `in_ready`=0.
- DONE:
  - `out_valid`=1 and `state_out` = working register.
  - `state_out` and `out_valid` stay stable until `out_ready`=1.
  - On `out_valid && out_ready`, go to IDLE.
  - `in_ready`=0 in DONE; there is no overlap of output and input handshakes.
- `state_out` is driven from the working register in all states. It is meaningful only while `out_valid`=1.
- `busy` = (state == BUSY).
- Changing `encrypt` after acceptance has no effect on the block in flight.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, `cnt`=0, `mode_q`=1, working register = 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `state_out`=0.
- Reset mid-operation aborts the block. No partial result is ever flagged valid.
- Latency: accept at edge N; `out_valid` rises after edge N+16 (16 BUSY cycles).
- Minimum initiation interval is 18 cycles: 16 BUSY cycles, 1 DONE cycle (with `out_ready`=1), and 1 IDLE accept cycle.
- `in_ready` depends only on the FSM state. It never depends combinationally on `in_valid`.
- The S-box path is combinational within one cycle: register → mux → ROM → register.

## Structure
- Shared include `aes_defs.vh` holds:
  - FSM state encodings `S_IDLE`=2'd0, `S_BUSY`=2'd1, `S_DONE`=2'd2 as localparams.
  - `AES_BLOCK_W`=128 and `AES_NBYTES`=16.
- One sub-module instance: `sbox_full_rom` (ports `encrypt`, `byte_in`, `byte_out`). Its memory files must be on the simulation path.
- Byte select and write-back use indexed part-selects on the working register. There is no per-byte mux tree duplication.

## Test plan
- All-zero block, `encrypt`=1:
  - `out_valid` after exactly 16 cycles.
  - `state_out` = 128'h63636363_63636363_63636363_63636363.
- FIPS-197 Appendix B round-1 SubBytes:
  - `state_in` = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, `encrypt`=1.
  - Expect `state_out` = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230.
- Inverse:
  - Feed the previous result back with `encrypt`=0.
  - Expect 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `state_out` stays stable, `in_ready` stays 0, and `in_valid` pulses are ignored.
  - After `out_ready`=1, IDLE is entered and the next block is accepted.
- Reset at BUSY cycle 7:
  - All outputs return to reset values immediately.
  - No `out_valid` occurs.
  - A subsequent all-zero block yields all-0x63.
- Mode latching:
  - Toggle `encrypt` every cycle during BUSY after accepting with `encrypt`=1.
  - The result equals the forward-S-box result.

Source files
------------

// File: rtl/aes_subbytes_seq_pkg.sv
// Shared types and GF(2^8) helpers for the sequential SubBytes/InvSubBytes stage.
// The S-box is computed arithmetically (inverse in GF(2^8) plus affine map).
package aes_subbytes_seq_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] p;
        sq = gf_mul(x, x);
        p  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gf_mul(sq, sq);
            p  = gf_mul(p, sq);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

endpackage

// File: rtl/sbox_full_rom.sv
// Forward/inverse AES S-box, purely combinational. Computed from the field
// inverse and affine map, so no memory initialisation files are needed.
module sbox_full_rom
    import aes_subbytes_seq_pkg::*;
(
    input  logic       encrypt,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    logic [7:0] t;

    always_comb begin
        t        = 8'h00;
        byte_out = 8'h00;
        if (encrypt) begin
            t        = gf_inv(byte_in);
            byte_out = t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
        end else begin
            t        = rotl8(byte_in, 1) ^ rotl8(byte_in, 3) ^ rotl8(byte_in, 6) ^ 8'h05;
            byte_out = gf_inv(t);
        end
    end

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential SubBytes/InvSubBytes: one byte per cycle through a single S-box.
//   state  | meaning
//   S_IDLE | waiting for a block, in_ready=1
//   S_BUSY | substituting byte[cnt], 16 cycles
//   S_DONE | result held on state_out until out_ready
module aes_subbytes_seq
    import aes_subbytes_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         encrypt,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [3:0]   cnt;
    logic         mode_q;
    logic [127:0] work;
    logic [6:0]   sel;
    logic [7:0]   sbox_in, sbox_out;
    logic         accept;

    // Byte 0 is the most significant byte of the block.
    assign sel     = 7'd127 - {cnt, 3'b000};
    assign sbox_in = work[sel -: 8];

    sbox_full_rom u_sbox (
        .encrypt  (mode_q),
        .byte_in  (sbox_in),
        .byte_out (sbox_out)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == 4'd15) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_BUSY);
    assign state_out = work;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 4'd0;
            mode_q <= 1'b1;
            work   <= '0;
        end else if (accept) begin
            cnt    <= 4'd0;
            mode_q <= encrypt;
            work   <= state_in;
        end else if (busy) begin
            work[sel -: 8] <= sbox_out;
            cnt            <= cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq against a table-based S-box model.
module tb_aes_subbytes_seq;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         encrypt;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    aes_subbytes_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .encrypt   (encrypt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    // Polynomial product, then reduction by 0x11b from the top bit down.
    function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] y, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int k = 1; k < 256; k++)
                if (x != 0 && poly_mul(8'(x), 8'(k)) == 8'h01) y = 8'(k);
            for (int i = 0; i < 8; i++)
                s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c[i];
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] blk, input bit enc);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = blk[127 - 8 * i -: 8];
            r[127 - 8 * i -: 8] = enc ? fwd_tab[b] : inv_tab[b];
        end
        return r;
    endfunction

    task automatic run_block(input logic [127:0] blk, input bit enc, input bit toggle,
                             input int hold, output logic [127:0] res);
        int cyc;
        check("in_ready_idle", 128'(in_ready), 128'd1);
        state_in  = blk;
        encrypt   = enc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        check("busy_after_accept", 128'(busy), 128'd1);
        check("in_ready_busy", 128'(in_ready), 128'd0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (toggle) encrypt = ~encrypt;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 128'(cyc), 128'd16);
        res = state_out;
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            @(posedge clk); #1;
            check("hold_state_out", state_out, res);
            check("hold_out_valid", 128'(out_valid), 128'd1);
            check("hold_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 128'(out_valid), 128'd0);
        check("idle_after_out", 128'(in_ready), 128'd1);
    endtask

    logic [127:0] res, blk;
    bit           enc;
    int           seen;

    initial begin
        reset_n   = 1'b0;
        encrypt   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        build_tables();
        #12;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_state_out", state_out, 128'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_block(128'd0, 1'b1, 1'b0, 0, res);
        check("zero_fwd", res, {16{8'h63}});

        run_block(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 1'b1, 1'b0, 0, res);
        check("fips_fwd", res, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230);

        run_block(res, 1'b0, 1'b0, 0, res);
        check("fips_inv", res, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);

        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(blk, 1'b1, 1'b0, 10, res);
        check("backpressure_result", res, model(blk, 1'b1));
        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(blk, 1'b0, 1'b0, 0, res);
        check("after_backpressure", res, model(blk, 1'b0));

        // Abort at BUSY cycle 7.
        state_in = '0;
        encrypt  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_state_out", state_out, 128'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", 128'(seen), 128'd0);
        run_block(128'd0, 1'b1, 1'b0, 0, res);
        check("zero_after_abort", res, {16{8'h63}});

        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(blk, 1'b1, 1'b1, 0, res);
        check("mode_latch_fwd", res, model(blk, 1'b1));
        run_block(blk, 1'b0, 1'b1, 0, res);
        check("mode_latch_inv", res, model(blk, 1'b0));

        for (int t = 0; t < 20; t++) begin
            blk = {$urandom(), $urandom(), $urandom(), $urandom()};
            enc = 1'($urandom_range(0, 1));
            run_block(blk, enc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), res);
            check("random_block", res, model(blk, enc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
